// File: rtl/playfield_mem_if.sv
// Bus bundle for playfield_mem: lock request, piece coordinates, row-read port and pass status.
// The master drives requests and read addresses; the slave (the field) returns data and status.
interface playfield_mem_if #(
  parameter int MEM_WIDTH = 10,
  parameter int WIDTH     = 8
);
  logic                   is_write_mem;
  logic [WIDTH*4-1:0]     new_coord_x_step_3;
  logic [WIDTH*4-1:0]     new_coord_y_step_3;
  logic [WIDTH-1:0]       rd_row;
  logic [MEM_WIDTH-1:0]   rd_data;
  logic                   busy;
  logic                   done;
  logic [2:0]             lines_cleared;
  logic                   err_overlap;
  logic [15:0]            score;

  modport master (
    output is_write_mem, new_coord_x_step_3, new_coord_y_step_3, rd_row,
    input  rd_data, busy, done, lines_cleared, err_overlap, score
  );

  modport slave (
    input  is_write_mem, new_coord_x_step_3, new_coord_y_step_3, rd_row,
    output rd_data, busy, done, lines_cleared, err_overlap, score
  );
endinterface

// File: rtl/playfield_mem.sv
// Tetris occupancy field: locks a 4-cell piece then clears full rows one row per cycle (PLAYFIELD_MEM_SCORE_EN adds score).
// Lock->done latency is 2+MEM_HEIGHT+2*cleared cycles; lock pulses arriving while busy are dropped, no backpressure.
module playfield_mem #(
  parameter int MEM_WIDTH  = 10,
  parameter int MEM_HEIGHT = 20,
  parameter int WIDTH      = 8
) (
  input  logic           clk,
  input  logic           rst,
  playfield_mem_if.slave pf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [WIDTH-1:0] X_LIM   = WIDTH'(MEM_WIDTH);
  localparam logic [WIDTH-1:0] Y_LIM   = WIDTH'(MEM_HEIGHT);
  localparam logic [WIDTH-1:0] ROW_BOT = WIDTH'(MEM_HEIGHT - 1);

  typedef logic [MEM_HEIGHT-1:0][MEM_WIDTH-1:0] field_t;

  field_t               field_q, field_d;
  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     ptr_q, ptr_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [2:0]           lines_q, lines_d;
  logic                 err_q, err_d;
  logic [WIDTH*4-1:0]   cx_q, cx_d, cy_q, cy_d;

  logic [WIDTH-1:0]     cell_x [4];
  logic [WIDTH-1:0]     cell_y [4];
  logic [MEM_WIDTH-1:0] cur_row;
  logic [MEM_WIDTH-1:0] rd_data_c;
  logic                 pass_end;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cell_x[k] = cx_q[WIDTH*(4-k)-1 -: WIDTH];
      cell_y[k] = cy_q[WIDTH*(4-k)-1 -: WIDTH];
    end
  end

  always_comb begin
    cur_row = '0;
    for (int i = 0; i < MEM_HEIGHT; i++) begin
      if (ptr_q == WIDTH'(i)) cur_row = field_q[i];
    end
  end

  // Out-of-range read rows match no entry and return zero.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < MEM_HEIGHT; i++) begin
      if (pf.rd_row == WIDTH'(i)) rd_data_c = field_q[i];
    end
  end

  assign pass_end = (state_q == S_SCAN) && !(&cur_row) && (ptr_q == '0);

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    err_d   = err_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    case (state_q)
      S_IDLE: begin
        if (pf.is_write_mem) begin
          cx_d    = pf.new_coord_x_step_3;
          cy_d    = pf.new_coord_y_step_3;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Overlap is judged against the pre-lock field, so duplicate cells within a piece never flag.
        for (int k = 0; k < 4; k++) begin
          if (cell_x[k] >= X_LIM || cell_y[k] >= Y_LIM) err_d = 1'b1;
          for (int r = 0; r < MEM_HEIGHT; r++) begin
            for (int c = 0; c < MEM_WIDTH; c++) begin
              if (cell_y[k] == WIDTH'(r) && cell_x[k] == WIDTH'(c)) begin
                if (field_q[r][c]) err_d = 1'b1;
                field_d[r][c] = 1'b1;
              end
            end
          end
        end
        ptr_d   = ROW_BOT;
        cnt_d   = 3'd0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (&cur_row) begin
          state_d = S_SHIFT;
        end else if (ptr_q == '0) begin
          lines_d = cnt_q;
          state_d = S_DONE;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      S_SHIFT: begin
        field_d[0] = '0;
        for (int i = 1; i < MEM_HEIGHT; i++) begin
          if (WIDTH'(i) <= ptr_q) field_d[i] = field_q[i-1];
        end
        cnt_d   = (cnt_q >= 3'd4) ? 3'd4 : cnt_q + 3'd1;
        state_d = S_SCAN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      field_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      err_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      err_q   <= err_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

`ifdef PLAYFIELD_MEM_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  always_comb begin
    score_sum = {1'b0, score_q} + 17'(cnt_q);
    score_d   = score_q;
    if (pass_end) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) score_q <= '0;
    else      score_q <= score_d;
  end

  assign pf.score = score_q;
`else
  assign pf.score = '0;
`endif

  assign pf.rd_data       = rd_data_c;
  assign pf.busy          = (state_q != S_IDLE);
  assign pf.done          = (state_q == S_DONE);
  assign pf.lines_cleared = lines_q;
  assign pf.err_overlap   = err_q;

endmodule

// File: tb/tb_playfield_mem.sv
// Directed bench for playfield_mem on a 4x4 field with a reference field model and a scoreboard of per-lock results.
module tb_playfield_mem;
  localparam int MW = 4;
  localparam int MH = 4;
  localparam int WD = 8;

  typedef struct {
    int   lines;
    int   lat;
    logic err;
    int   score;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  playfield_mem_if #(.MEM_WIDTH(MW), .WIDTH(WD)) pf();

  playfield_mem #(.MEM_WIDTH(MW), .MEM_HEIGHT(MH), .WIDTH(WD)) dut (
    .clk (clk),
    .rst (rst),
    .pf  (pf)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb [$];
  logic [MW-1:0] mdl [MH];
  logic        mdl_err;
  int          mdl_score;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {WD'(a), WD'(b), WD'(c), WD'(d)};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < MH; r++) mdl[r] = '0;
    mdl_err   = 1'b0;
    mdl_score = 0;
  endtask

  // Reference: set cells, then rebuild the field bottom-up keeping only non-full rows.
  task automatic model_lock(input logic [31:0] x, input logic [31:0] y);
    logic [MW-1:0] pre [MH];
    logic [MW-1:0] nf  [MH];
    int xi, yi, w, lines;
    pre = mdl;
    for (int k = 0; k < 4; k++) begin
      xi = int'(x[WD*(4-k)-1 -: WD]);
      yi = int'(y[WD*(4-k)-1 -: WD]);
      if (xi >= MW || yi >= MH) mdl_err = 1'b1;
      else begin
        if (pre[yi][xi]) mdl_err = 1'b1;
        mdl[yi][xi] = 1'b1;
      end
    end
    for (int r = 0; r < MH; r++) nf[r] = '0;
    w = MH - 1;
    lines = 0;
    for (int r = MH - 1; r >= 0; r--) begin
      if (mdl[r] != '1) begin
        nf[w] = mdl[r];
        w--;
      end else lines++;
    end
    mdl = nf;
`ifdef PLAYFIELD_MEM_SCORE_EN
    mdl_score = (mdl_score + lines > 65535) ? 65535 : mdl_score + lines;
`endif
    sb.push_back('{lines, 2 + MH + 2 * lines, mdl_err, mdl_score});
  endtask

  task automatic check_field(input string tag);
    logic [MW-1:0] e;
    for (int r = 0; r <= MH; r++) begin
      pf.rd_row = WD'(r);
      #1;
      e = (r < MH) ? mdl[r] : '0;
      chk($sformatf("%s_row%0d", tag, r), 32'(pf.rd_data), 32'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(pf.busy), 32'(0));
    chk({tag, "_done"},  32'(pf.done), 32'(0));
    chk({tag, "_lines"}, 32'(pf.lines_cleared), 32'(0));
    chk({tag, "_err"},   32'(pf.err_overlap), 32'(0));
    chk({tag, "_score"}, 32'(pf.score), 32'(0));
    check_field(tag);
  endtask

  // Drives one lock, optionally pulses a second request at cycle inj_at, or resets at cycle abort_at.
  task automatic lock(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input int inj_at, input logic [31:0] ix, input logic [31:0] iy,
                      input int abort_at);
    int   lat;
    bit   seen;
    int   extra;
    exp_t e;
    @(negedge clk);
    pf.new_coord_x_step_3 = x;
    pf.new_coord_y_step_3 = y;
    pf.is_write_mem       = 1'b1;
    model_lock(x, y);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      pf.is_write_mem = 1'b0;
      if (lat == inj_at) begin
        pf.new_coord_x_step_3 = ix;
        pf.new_coord_y_step_3 = iy;
        pf.is_write_mem       = 1'b1;
      end
      if (lat == abort_at) begin
        pf.rd_row = WD'(MH - 1);
        #1;
        chk({tag, "_mid_pass_row"}, 32'(pf.rd_data), 32'({MW{1'b1}}));
        chk({tag, "_mid_pass_busy"}, 32'(pf.busy), 32'(1));
        rst = 1'b0;
        #1;
        check_reset_outputs({tag, "_abort"});
        void'(sb.pop_front());
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (pf.done) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'(1));
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'(0), 32'(sb.size() + 1));
      return;
    end
    e = sb.pop_front();
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_lines"},   32'(pf.lines_cleared), 32'(e.lines));
      chk({tag, "_err"},     32'(pf.err_overlap), 32'(e.err));
      chk({tag, "_score"},   32'(pf.score), 32'(e.score));
      chk({tag, "_busy_at_done"}, 32'(pf.busy), 32'(1));
    end
    @(negedge clk);
    pf.is_write_mem = 1'b0;
    chk({tag, "_busy_after"}, 32'(pf.busy), 32'(0));
    chk({tag, "_done_after"}, 32'(pf.done), 32'(0));
    check_field(tag);
    if (inj_at > 0) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (pf.done || pf.busy) extra++;
      end
      chk({tag, "_no_second_pass"}, 32'(extra), 32'(0));
      check_field({tag, "_late"});
    end
  endtask

  initial begin
    rst                   = 1'b0;
    pf.is_write_mem       = 1'b0;
    pf.new_coord_x_step_3 = '0;
    pf.new_coord_y_step_3 = '0;
    pf.rd_row             = '0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Full bottom row clears; latency 2+4+2.
    lock("row3_full", pk(0, 1, 2, 3), pk(3, 3, 3, 3), 0, 0, 0, 0);
    // Prefill rows 2 and 3 with columns 0..2; second piece uses duplicate cells.
    lock("prefill_a", pk(0, 1, 2, 0), pk(3, 3, 3, 2), 0, 0, 0, 0);
    lock("prefill_b", pk(1, 2, 2, 2), pk(2, 2, 2, 2), 0, 0, 0, 0);
    // Vertical piece in column 3 clears two rows.
    lock("vertical", pk(3, 3, 3, 3), pk(0, 1, 2, 3), 0, 0, 0, 0);
    // Second request mid-pass must be dropped.
    lock("busy_ignore", pk(0, 1, 0, 1), pk(0, 0, 1, 1), 3, pk(2, 2, 3, 3), pk(0, 1, 0, 1), 0);
    // Lock onto an occupied cell.
    lock("overlap", pk(0, 2, 2, 1), pk(0, 0, 1, 2), 0, 0, 0, 0);
    // Clean lock clearing row 0; request coincident with done is dropped; err stays sticky.
    lock("row0_clear", pk(3, 3, 3, 3), pk(0, 0, 0, 0), 8, pk(0, 1, 2, 3), pk(3, 3, 3, 3), 0);

    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("err_cleared_by_reset", 32'(pf.err_overlap), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Reset asserted while the pass is in SHIFT.
    lock("abort", pk(0, 1, 2, 3), pk(3, 3, 3, 3), 0, 0, 0, 3);
    lock("post_reset", pk(0, 1, 1, 2), pk(3, 3, 2, 3), 0, 0, 0, 0);
    // x == MEM_WIDTH is dropped; the other three cells land.
    lock("x_oob", pk(MW, 0, 1, 3), pk(0, 0, 0, 1), 0, 0, 0, 0);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/playfield_mem.md
Name: playfield_mem

Overview:
- Parametrised Tetris playfield store: MEM_HEIGHT rows × MEM_WIDTH columns of occupancy bits.
- On `is_write_mem` it locks the four cells of the landed piece into the field (coordinates from pipeline step 3).
- It then runs a sequential line-clear pass that removes full rows and collapses the rows above them.
- Provides a combinational row-read port for collision checking and display, plus a per-lock cleared-line count.

Parameters:
- MEM_WIDTH, 10, columns per row (bits per row word)
- MEM_HEIGHT, 20, number of rows; row 0 = top, row MEM_HEIGHT-1 = bottom
- WIDTH, 8, width of each coordinate field; must satisfy 2^WIDTH > max(MEM_WIDTH, MEM_HEIGHT)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- is_write_mem  input  1  lock request, one-cycle pulse
- new_coord_x_step_3  input  WIDTH*4  column of cells 0..3; cell k at bits [WIDTH*(4-k)-1 : WIDTH*(3-k)]
- new_coord_y_step_3  input  WIDTH*4  row of cells 0..3, same packing as x
- rd_row  input  WIDTH  row index for the read port
- rd_data  output  MEM_WIDTH  occupancy of rd_row; bit c = column c; all zeros if rd_row >= MEM_HEIGHT
- busy  output  1  high from accepted lock until the cycle after done
- done  output  1  one-cycle pulse when the lock and clear pass completes
- lines_cleared  output  3  rows removed by the last lock (0..4), valid from done until the next done
- err_overlap  output  1  sticky; set when a lock writes an already-occupied cell or an out-of-range coordinate
- score  output  16  total cleared lines (see Optional Feature)

Behaviour:
- Reset (rst low, async): all field bits 0, FSM IDLE, busy=0, done=0, lines_cleared=0, err_overlap=0, score=0.
- Reset asserted mid-pass aborts the pass immediately; the field is cleared.
- rd_data is combinational from the current field contents, including during a pass (shows intermediate state).
- FSM states: IDLE, WRITE, SCAN, SHIFT, DONE.
- IDLE:
  - is_write_mem=1 → latch the four coordinates; busy=1 next cycle; go to WRITE.
  - is_write_mem while busy is ignored; no queueing.
- WRITE (1 cycle):
  - Set field[y_k][x_k] for each in-range cell k.
  - Out-of-range cells (x >= MEM_WIDTH or y >= MEM_HEIGHT) are dropped and set err_overlap.
  - Writing a cell already at 1 sets err_overlap; the bit stays 1.
  - Duplicate coordinates within one piece count as a single write and do not set err_overlap.
  - Row pointer r ← MEM_HEIGHT-1; clear counter ← 0; go to SCAN.
- SCAN (1 cycle per row):
  - Row r all ones → SHIFT.
  - Otherwise, if r == 0 → DONE; else r ← r-1 and stay in SCAN.
- SHIFT (1 cycle):
  - Rows r..1 take the contents of rows r-1..0; row 0 ← 0; counter += 1.
  - Return to SCAN with r unchanged, so the collapsed row is rechecked.
- DONE (1 cycle): done=1; lines_cleared ← counter; go to IDLE. busy falls the following cycle.
- Latency: lock pulse to done = 2 + MEM_HEIGHT + 2×(lines cleared) cycles.
- The counter saturates at 4 in the 3-bit output.
- A full row 0 that gets cleared is handled the same way: row 0 ← 0, then it is rescanned and found not full.
- Simultaneous is_write_mem and DONE: the request is ignored because busy is still 1.

Optional Feature:
- Macro: PLAYFIELD_MEM_SCORE_EN.
- Defined: score accumulates lines_cleared at each DONE, saturating at 16'hFFFF; reset to 0.
- Not defined: score is tied to 0 and no accumulator flops are inferred. The port is always present.

Test Plan:
- Reset, then lock cells (0,19),(1,19),(2,19),(3,19) with MEM_WIDTH=4, MEM_HEIGHT=4 adjusted so y=3 → row 3 = 4'b1111 becomes 0; done after 2+4+2 = 8 cycles; lines_cleared=1; score=1 with the macro.
- Prefill rows 2 and 3 to 3 bits each, then lock a vertical piece in the missing column covering rows 0..3 → rows 2 and 3 clear; rows 0,1 (1 bit each) shift to rows 2,3; lines_cleared=2.
- Lock onto an occupied cell → err_overlap=1 and stays 1 through subsequent clean locks until reset.
- Lock with x=MEM_WIDTH → that cell is dropped, err_overlap=1, the other three cells are written.
- Pulse is_write_mem again while busy=1 → ignored; exactly one done; field reflects only the first piece.
- Drop rst low during SHIFT → all outputs 0 asynchronously; rd_data=0 for every row; a new lock afterwards completes normally.
